// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: keeps E/M/W destination records and derives stall
// and operand-forwarding selects from Tuse/Tnew timing.
module hazard_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [2:0]  Tuse_rs,
  input  logic [2:0]  Tuse_rt,
  input  logic [4:0]  wa_D,
  input  logic        we_D,
  input  logic [2:0]  Tnew_D,
  output logic        stall,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic [31:0] stall_cnt
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic       we;
    logic [2:0] tnew;
  } e_rec_t;

  // M only needs rt (store data) and W needs no sources, so those are not kept.
  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wa;
    logic       we;
    logic [2:0] tnew;
  } m_rec_t;

  typedef struct packed {
    logic [4:0] wa;
    logic       we;
    logic [2:0] tnew;
  } w_rec_t;

  e_rec_t e_q;
  m_rec_t m_q;
  w_rec_t w_q;

  function automatic logic [2:0] dec(input logic [2:0] x);
    return (x != 3'd0) ? x - 3'd1 : 3'd0;
  endfunction

  function automatic logic hit(input logic we, input logic [4:0] wa, input logic [4:0] r);
    return we && (wa == r) && (r != 5'd0);
  endfunction

  // A stage still producing its result neither forwards nor shadows older stages.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] r, input e_rec_t e,
                                           input m_rec_t m, input w_rec_t w);
    if (hit(e.we, e.wa, r) && e.tnew == 3'd0)      return 2'd1;
    else if (hit(m.we, m.wa, r) && m.tnew == 3'd0) return 2'd2;
    else if (hit(w.we, w.wa, r) && w.tnew == 3'd0) return 2'd3;
    else                                           return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] r, input m_rec_t m,
                                           input w_rec_t w);
    if (hit(m.we, m.wa, r) && m.tnew == 3'd0) return 2'd2;
    else if (hit(w.we, w.wa, r))              return 2'd3;
    else                                      return 2'd0;
  endfunction

  function automatic logic needs_stall(input logic [4:0] r, input logic [2:0] tuse,
                                       input e_rec_t e, input m_rec_t m);
    return (hit(e.we, e.wa, r) && e.tnew > tuse) ||
           (hit(m.we, m.wa, r) && m.tnew > tuse);
  endfunction

  always_comb begin
    stall    = needs_stall(rs_D, Tuse_rs, e_q, m_q) || needs_stall(rt_D, Tuse_rt, e_q, m_q);
    fwd_rs_D = fwd_d_sel(rs_D, e_q, m_q, w_q);
    fwd_rt_D = fwd_d_sel(rt_D, e_q, m_q, w_q);
    fwd_rs_E = fwd_e_sel(e_q.rs, m_q, w_q);
    fwd_rt_E = fwd_e_sel(e_q.rt, m_q, w_q);
    fwd_rt_M = hit(w_q.we, w_q.wa, m_q.rt);
  end

  // A stall replaces the incoming D instruction with a bubble; M and W always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall) begin
        e_q       <= '0;
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        e_q <= {rs_D, rt_D, wa_D, we_D, dec(Tnew_D)};
      end
      m_q <= {e_q.rt, e_q.wa, e_q.we, dec(e_q.tnew)};
      w_q <= {m_q.wa, m_q.we, dec(m_q.tnew)};
    end
  end

endmodule
